// File: rtl/image_pkg.sv
// Shared definitions for the line-buffer image path: feeder state encoding, width helper, common defaults.
// FEEDER_PAD_LINES_EN adds the PAD/PAD_WAIT states to the encoding.
package image_pkg;

    localparam int PIXEL_WIDTH_DEF = 8;
    localparam int LINE_WIDTH_DEF  = 512;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND     = 3'd1,
        WAIT     = 3'd2,
`ifdef FEEDER_PAD_LINES_EN
        DRAIN    = 3'd3,
        PAD      = 3'd4,
        PAD_WAIT = 3'd5
`else
        DRAIN    = 3'd3
`endif
    } feeder_state_e;

    // Bits needed to hold a counter running 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/line_credit_counter.sv
// Line credit counter: load to BUFFER_COUNT, +1 per returned line, -1 per issued line, saturating at both ends.
module line_credit_counter #(
    parameter int BUFFER_COUNT = 4,
    parameter int CRED_WIDTH   = $clog2(BUFFER_COUNT+1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_inc,
    input  logic                  i_dec,
    input  logic                  i_load,
    output logic [CRED_WIDTH-1:0] o_count,
    output logic [CRED_WIDTH-1:0] o_count_next
);

    localparam logic [CRED_WIDTH-1:0] CRED_MAX = CRED_WIDTH'(BUFFER_COUNT);

    logic [CRED_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = CRED_MAX;
        end else if (i_inc && !i_dec && (count_q != CRED_MAX)) begin
            count_d = count_q + 1'b1;
        end else if (i_dec && !i_inc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count      = count_q;
    assign o_count_next = count_d;

endmodule

// File: rtl/pixel_line_feeder.sv
// Credit-gated row-major frame reader feeding the line-buffer controller, one pixel per cycle.
// FEEDER_PAD_LINES_EN appends PAD_LINES zero lines after the frame.
module pixel_line_feeder
    import image_pkg::*;
#(
    parameter int  PIXEL_WIDTH  = PIXEL_WIDTH_DEF,
    parameter int  LINE_WIDTH   = LINE_WIDTH_DEF,
    parameter int  IMAGE_HEIGHT = 512,
    parameter int  BUFFER_COUNT = 4,
    parameter int  PAD_LINES    = 2,
    localparam int ADDR_WIDTH   = $clog2(LINE_WIDTH*IMAGE_HEIGHT),
    localparam int CRED_WIDTH   = $clog2(BUFFER_COUNT+1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_intr,
    output logic                   o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    input  logic [PIXEL_WIDTH-1:0] i_mem_data,
    output logic [PIXEL_WIDTH-1:0] o_pixel_data,
    output logic                   o_pixel_data_valid,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int PIX_W  = cnt_width(LINE_WIDTH);
    localparam int LINE_W = cnt_width(IMAGE_HEIGHT);

    // A zero pad count would make the last-pad-line compare wrap.
    if (PAD_LINES < 1) begin : g_pad_lines_check
        $error("PAD_LINES must be at least 1");
    end

    feeder_state_e          state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [PIX_W-1:0]       pix_q;
    logic [LINE_W-1:0]      line_q;
    logic                   rd_en_q;
    logic                   v1_q;
    logic [PIXEL_WIDTH-1:0] pixel_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   issuing, last_pix, last_line;
    logic                   start_acc, cred_inc, cred_dec;
    logic [CRED_WIDTH-1:0]  cred_q, cred_d;

`ifdef FEEDER_PAD_LINES_EN
    localparam int PADL_W = cnt_width(PAD_LINES);
    logic              pad_iss_q;
    logic              pad1_q;
    logic [PADL_W-1:0] pad_line_q;
    assign issuing = rd_en_q | pad_iss_q;
`else
    assign issuing = rd_en_q;
`endif

    assign last_pix  = issuing && (pix_q == PIX_W'(LINE_WIDTH-1));
    assign last_line = (line_q == LINE_W'(IMAGE_HEIGHT-1));
    assign start_acc = (state_q == IDLE) && i_start;
    assign cred_inc  = i_intr && (state_q != IDLE);
    assign cred_dec  = last_pix;

    line_credit_counter #(
        .BUFFER_COUNT(BUFFER_COUNT),
        .CRED_WIDTH  (CRED_WIDTH)
    ) u_credit (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_inc       (cred_inc),
        .i_dec       (cred_dec),
        .i_load      (start_acc),
        .o_count     (cred_q),
        .o_count_next(cred_d)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pix_q   <= '0;
            line_q  <= '0;
            rd_en_q <= 1'b0;
            v1_q    <= 1'b0;
            pixel_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FEEDER_PAD_LINES_EN
            pad_iss_q  <= 1'b0;
            pad1_q     <= 1'b0;
            pad_line_q <= '0;
`endif
        end else begin
            done_q  <= 1'b0;
            v1_q    <= issuing;
            valid_q <= v1_q;
`ifdef FEEDER_PAD_LINES_EN
            pad1_q <= pad_iss_q;
            if (v1_q) pixel_q <= pad1_q ? '0 : i_mem_data;
`else
            if (v1_q) pixel_q <= i_mem_data;
`endif
            if (issuing) pix_q <= last_pix ? '0 : pix_q + 1'b1;
            // Address stays on the last pixel of the frame until the next start.
            if (rd_en_q && !(last_pix && last_line)) addr_q <= addr_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_q <= SEND;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                        addr_q  <= '0;
                        line_q  <= '0;
                        pix_q   <= '0;
`ifdef FEEDER_PAD_LINES_EN
                        pad_line_q <= '0;
`endif
                    end
                end
                SEND: begin
                    if (last_pix) begin
                        if (last_line) begin
                            rd_en_q <= 1'b0;
`ifdef FEEDER_PAD_LINES_EN
                            if (cred_d != '0) begin
                                state_q   <= PAD;
                                pad_iss_q <= 1'b1;
                            end else begin
                                state_q <= PAD_WAIT;
                            end
`else
                            state_q <= DRAIN;
`endif
                        end else begin
                            line_q <= line_q + 1'b1;
                            if (cred_d == '0) begin
                                rd_en_q <= 1'b0;
                                state_q <= WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (cred_q != '0) begin
                        state_q <= SEND;
                        rd_en_q <= 1'b1;
                    end
                end
`ifdef FEEDER_PAD_LINES_EN
                PAD: begin
                    if (last_pix) begin
                        if (pad_line_q == PADL_W'(PAD_LINES-1)) begin
                            pad_iss_q <= 1'b0;
                            state_q   <= DRAIN;
                        end else begin
                            pad_line_q <= pad_line_q + 1'b1;
                            if (cred_d == '0) begin
                                pad_iss_q <= 1'b0;
                                state_q   <= PAD_WAIT;
                            end
                        end
                    end
                end
                PAD_WAIT: begin
                    if (cred_q != '0) begin
                        state_q   <= PAD;
                        pad_iss_q <= 1'b1;
                    end
                end
`endif
                DRAIN: begin
                    // Last pixel is in the output register now; done lands the cycle after it.
                    if (!v1_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rd_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_rd_en        = rd_en_q;
    assign o_mem_addr         = addr_q;
    assign o_pixel_data       = pixel_q;
    assign o_pixel_data_valid = valid_q;
    assign o_busy             = busy_q;
    assign o_done             = done_q;

endmodule

// File: tb/tb_pixel_line_feeder.sv
// Directed bench for pixel_line_feeder: 8x6 frame, 4 credits, memory data = address[7:0].
// With FEEDER_PAD_LINES_EN defined, frame completion expects two trailing zero lines.
module tb_pixel_line_feeder;

    localparam int LW = 8;
    localparam int IH = 6;
`ifdef FEEDER_PAD_LINES_EN
    localparam int EXP_TOTAL = 64;
`else
    localparam int EXP_TOTAL = 48;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       intr = 1'b0;
    logic       rd_en;
    logic [5:0] addr;
    logic [7:0] mem_q = 8'd0;
    logic [7:0] pixel;
    logic       valid;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [7:0] pix_log[$];
    int         stamp_log[$];
    int         first_rd = -1;
    int         rd_cnt = 0;
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         busy_at_done = -1;

    pixel_line_feeder #(
        .PIXEL_WIDTH (8),
        .LINE_WIDTH  (LW),
        .IMAGE_HEIGHT(IH),
        .BUFFER_COUNT(4),
        .PAD_LINES   (2)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_start           (start),
        .i_intr            (intr),
        .o_mem_rd_en       (rd_en),
        .o_mem_addr        (addr),
        .i_mem_data        (mem_q),
        .o_pixel_data      (pixel),
        .o_pixel_data_valid(valid),
        .o_busy            (busy),
        .o_done            (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) mem_q <= 8'(addr);
    end

    always @(negedge clk) begin
        if (valid) begin
            pix_log.push_back(pixel);
            stamp_log.push_back(cyc);
        end
        if (rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = int'(busy);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int at(input int i);
        return (i < pix_log.size()) ? int'(pix_log[i]) : -1;
    endfunction

    function automatic int st(input int i);
        return (i < stamp_log.size()) ? stamp_log[i] : -100;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_intr();
        @(negedge clk) intr = 1'b1;
        @(negedge clk) intr = 1'b0;
    endtask

    task automatic clear_log();
        pix_log.delete();
        stamp_log.delete();
        first_rd = -1;
        rd_cnt = 0;
    endtask

    task automatic wait_rd(input string tag);
        for (int i = 0; i < 10 && !rd_en; i++) @(negedge clk);
        chk(tag, int'(rd_en), 1);
    endtask

    task automatic finish_frame(input string tag);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 300 && done_cnt == d0; i++) begin
            intr = (i % 12 == 0);
            @(negedge clk);
        end
        intr = 1'b0;
        chk(tag, done_cnt - d0, 1);
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        step(2);

        // Partial frame, then asynchronous reset in the middle of a cycle.
        pulse_start();
        step(6);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_pixel", int'(pixel), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk) rst = 1'b0;
        step(2);
        chk("rst_no_done", done_cnt, 0);
        clear_log();

        // Frame 1: initial 4-line burst, with a start pulse that must be ignored mid-burst.
        pulse_start();
        step(10);
        pulse_start();
        step(50);
        chk("burst_count", pix_log.size(), 32);
        for (int i = 0; i < 32; i++) chk($sformatf("burst_pix%0d", i), at(i), i);
        chk("burst_latency", st(0) - first_rd, 2);
        chk("burst_contig", st(31) - st(0), 31);
        chk("burst_busy", int'(busy), 1);
        chk("burst_stalled", int'(rd_en), 0);
        chk("burst_no_done", done_cnt, 0);

        pulse_intr();
        step(20);
        chk("credit_count", pix_log.size(), 40);
        for (int i = 32; i < 40; i++) chk($sformatf("credit_pix%0d", i), at(i), i);
        chk("credit_stalled", int'(rd_en), 0);
        chk("credit_no_done", done_cnt, 0);

        pulse_intr();
        pulse_intr();
        step(20);
        for (int i = 40; i < 48; i++) chk($sformatf("last_pix%0d", i), at(i), i);
`ifdef FEEDER_PAD_LINES_EN
        pulse_intr();
        pulse_intr();
        step(30);
        for (int i = 48; i < 64; i++) chk($sformatf("pad_pix%0d", i), at(i), 0);
`endif
        chk("frame_count", pix_log.size(), EXP_TOTAL);
        chk("frame_done_cnt", done_cnt, 1);
        chk("done_after_last", done_cyc - st(EXP_TOTAL-1), 1);
        chk("busy_at_done", busy_at_done, 0);
        chk("busy_after", int'(busy), 0);
        chk("addr_hold", int'(addr), 47);

        // Frame 2: credit returned on the last-pixel issue of line 3.
        clear_log();
        pulse_start();
        wait_rd("f2_rd_seen");
        chk("f2_addr_restart", int'(addr), 0);
        step(31);
        intr = 1'b1;
        step(1);
        intr = 1'b0;
        step(30);
        chk("coinc_count", pix_log.size(), 40);
        chk("coinc_no_gap", st(32) - st(31), 1);
        chk("coinc_pix39", at(39), 39);
        chk("coinc_stalled", int'(rd_en), 0);
        finish_frame("f2_done");
        chk("f2_total", pix_log.size(), EXP_TOTAL);

        // Frame 3: five returns while credits are already full must be dropped.
        clear_log();
        pulse_start();
        wait_rd("f3_rd_seen");
        step(1);
        intr = 1'b1;
        step(5);
        intr = 1'b0;
        step(50);
        chk("sat_count", pix_log.size(), 32);
        chk("sat_rd_cnt", rd_cnt, 32);
        chk("sat_stalled", int'(rd_en), 0);
        finish_frame("f3_done");
        step(30);
        chk("sat_total", pix_log.size(), EXP_TOTAL);
        chk("sat_rd_total", rd_cnt, 48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
